// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types plus the error-responder FIFO entry
package tlul_pkg;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int DBW = DW / 8;
   localparam int SZW = 2;
   localparam int IW  = 8;
   localparam int DIW = 1;
   localparam int UW  = 8;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic             a_valid;
      tl_a_op_e         a_opcode;
      logic [2:0]       a_param;
      logic [SZW-1:0]   a_size;
      logic [IW-1:0]    a_source;
      logic [AW-1:0]    a_address;
      logic [DBW-1:0]   a_mask;
      logic [DW-1:0]    a_data;
      logic [UW-1:0]    a_user;
      logic             d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic             d_valid;
      tl_d_op_e         d_opcode;
      logic [2:0]       d_param;
      logic [SZW-1:0]   d_size;
      logic [IW-1:0]    d_source;
      logic [DIW-1:0]   d_sink;
      logic [DW-1:0]    d_data;
      logic [UW-1:0]    d_user;
      logic             d_error;
      logic             a_ready;
   } tl_d2h_t;

   typedef struct packed {
      tl_d_op_e         op;
      logic [SZW-1:0]   size;
      logic [IW-1:0]    source;
   } tl_err_rsp_t;

   localparam tl_err_rsp_t ErrRspReset = '0;

   // Only reads return data; every other opcode, known or not, is a plain ack.
   function automatic tl_d_op_e err_rsp_op(input tl_a_op_e op);
      return (op == Get) ? AccessAckData : AccessAck;
   endfunction

endpackage

// File: rtl/tlul_err_resp_fifo.sv
// rtl/tlul_err_resp_fifo.sv - synchronous FIFO of pending error responses
module tlul_err_resp_fifo
   import tlul_pkg::*;
#(
   parameter int Depth = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wvalid,
   output logic        o_wready,
   input  tl_err_rsp_t i_wdata,
   output logic        o_rvalid,
   input  logic        i_rready,
   output tl_err_rsp_t o_rdata
);

   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);

   tl_err_rsp_t       r_mem [Depth];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_cnt;
   logic              w_push;
   logic              w_pop;

   assign o_wready = (r_cnt != CW'(Depth));
   assign o_rvalid = (r_cnt != '0);
   assign w_push   = i_wvalid & o_wready;
   assign w_pop    = o_rvalid & i_rready;
   assign o_rdata  = r_mem[r_rptr];

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointers wrap explicitly so Depth need not be a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
         end
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/tlul_err_resp.sv
// rtl/tlul_err_resp.sv - TL-UL default device answering every request with d_error
// Optional saturating response counter on err_cnt_o when TLUL_ERR_RESP_CNT_EN is defined.
module tlul_err_resp
   import tlul_pkg::*;
#(
   parameter int            Depth   = 2,
   parameter logic [DW-1:0] ErrData = 32'hFFFF_FFFF
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  tl_h2d_t tl_i,
   output tl_d2h_t tl_o
`ifdef TLUL_ERR_RESP_CNT_EN
   ,
   output logic [15:0] err_cnt_o
`endif
);

   tl_err_rsp_t w_wdata;
   tl_err_rsp_t w_rdata;
   tl_err_rsp_t w_head;
   logic        w_wready;
   logic        w_rvalid;
   logic        w_unused;

   assign w_wdata.op     = err_rsp_op(tl_i.a_opcode);
   assign w_wdata.size   = tl_i.a_size;
   assign w_wdata.source = tl_i.a_source;

   tlul_err_resp_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_wvalid (tl_i.a_valid),
      .o_wready (w_wready),
      .i_wdata  (w_wdata),
      .o_rvalid (w_rvalid),
      .i_rready (tl_i.d_ready),
      .o_rdata  (w_rdata)
   );

   // Stale storage must not leak onto an idle D channel.
   assign w_head = w_rvalid ? w_rdata : ErrRspReset;

   assign tl_o.d_valid  = w_rvalid;
   assign tl_o.d_opcode = w_head.op;
   assign tl_o.d_param  = '0;
   assign tl_o.d_size   = w_head.size;
   assign tl_o.d_source = w_head.source;
   assign tl_o.d_sink   = '0;
   assign tl_o.d_data   = (w_head.op == AccessAckData) ? ErrData : '0;
   assign tl_o.d_user   = '0;
   assign tl_o.d_error  = w_rvalid;
   assign tl_o.a_ready  = w_wready;

   assign w_unused = ^{tl_i.a_param, tl_i.a_address, tl_i.a_mask, tl_i.a_data, tl_i.a_user};

`ifdef TLUL_ERR_RESP_CNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err_cnt <= '0;
      end else if (w_rvalid && tl_i.d_ready && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign err_cnt_o = r_err_cnt;
`endif

endmodule
